// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes and FSM states.
package mem_stage_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: store data replication/strobes, load extraction/extension,
// and the fault check (illegal funct3 or misaligned offset).
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_is_store,
    input  logic [1:0]  i_addr_off,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_load_data,
    output logic        o_fault
);

    logic [31:0] w_shifted;

    assign w_shifted = i_load_word >> {i_addr_off, 3'b000};

    always_comb begin
        o_wdata     = 32'd0;
        o_wstrb     = 4'd0;
        o_load_data = 32'd0;
        o_fault     = 1'b0;
        case (i_funct3)
            F3_LB: begin
                o_wdata     = {4{i_store_data[7:0]}};
                o_wstrb     = 4'b0001 << i_addr_off;
                o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            F3_LH: begin
                o_fault     = i_addr_off[0];
                o_wdata     = {2{i_store_data[15:0]}};
                o_wstrb     = 4'b0011 << i_addr_off;
                o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            F3_LW: begin
                o_fault     = |i_addr_off;
                o_wdata     = i_store_data;
                o_wstrb     = 4'b1111;
                o_load_data = i_load_word;
            end
            // Unsigned variants exist only for loads.
            F3_LBU: begin
                o_fault     = i_is_store;
                o_load_data = {24'd0, w_shifted[7:0]};
            end
            F3_LHU: begin
                o_fault     = i_is_store | i_addr_off[0];
                o_load_data = {16'd0, w_shifted[15:0]};
            end
            default: o_fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: issues one load/store at a time over a valid/ready bus, stalls
// upstream while waiting, and registers the MEM/WB payload.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] alu_out_in,
    input  logic [31:0] rs2_data_in,
    input  logic [31:0] current_pc_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc,
    output logic        misalign_out,
    output logic        bus_err,
    output logic        dbg_state
);

    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : TIMEOUT_CYCLES - 1;

    lsu_state_e  r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_pc, r_tmo_cnt;
    logic [3:0]  r_wstrb;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_we, r_reg_write;

    logic        r_wb_valid, r_wb_reg_write, r_misalign, r_bus_err;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data, r_wb_pc;

    logic        w_is_req, w_mem_op, w_accept, w_bad, w_done, w_timeout, w_fault;
    logic [31:0] w_wdata, w_load_data;
    logic [3:0]  w_wstrb;

    assign w_is_req  = (r_state == ST_REQ);
    assign w_mem_op  = ex_valid & (ex_mem_read | ex_mem_write);
    assign w_accept  = ~w_is_req & w_mem_op & ~w_fault;
    assign w_bad     = ~w_is_req & w_mem_op & w_fault;
    assign w_done    = w_is_req & dmem_ready;
    assign w_timeout = TMO_EN & w_is_req & ~dmem_ready & (r_tmo_cnt == TMO_LAST);

    // In REQ the aligner works on the held access so the load extract sees its offset.
    mem_stage_lsu_align u_align (
        .i_funct3     (w_is_req ? r_funct3 : ex_funct3),
        .i_is_store   (w_is_req ? r_we : ex_mem_write),
        .i_addr_off   (w_is_req ? r_addr[1:0] : alu_out_in[1:0]),
        .i_store_data (rs2_data_in),
        .i_load_word  (dmem_rdata),
        .o_wdata      (w_wdata),
        .o_wstrb      (w_wstrb),
        .o_load_data  (w_load_data),
        .o_fault      (w_fault)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_REQ;
            ST_REQ:  if (dmem_ready || w_timeout) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Bus is driven only in REQ; stall drops in the completion cycle so upstream advances.
    always_comb begin
        stall_out  = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        dmem_wstrb = 4'd0;
        dbg_state  = 1'b0;
        case (r_state)
            ST_IDLE: stall_out = rst & w_accept;
            ST_REQ: begin
                stall_out  = rst & ~dmem_ready & ~w_timeout;
                dmem_req   = 1'b1;
                dmem_we    = r_we;
                dmem_addr  = {r_addr[31:2], 2'b00};
                dmem_wdata = r_wdata;
                dmem_wstrb = r_we ? r_wstrb : 4'd0;
                dbg_state  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_rd        <= 5'd0;
            r_pc        <= 32'd0;
            r_reg_write <= 1'b0;
        end else if (w_accept) begin
            r_addr      <= alu_out_in;
            r_wdata     <= w_wdata;
            r_wstrb     <= w_wstrb;
            r_we        <= ex_mem_write;
            r_funct3    <= ex_funct3;
            r_rd        <= ex_rd;
            r_pc        <= current_pc_in;
            r_reg_write <= ex_reg_write & ex_mem_read;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)                                      r_tmo_cnt <= 32'd0;
        else if (w_is_req && !dmem_ready && !w_timeout) r_tmo_cnt <= r_tmo_cnt + 32'd1;
        else                                           r_tmo_cnt <= 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= 5'd0;
            r_wb_data      <= 32'd0;
            r_wb_pc        <= 32'd0;
            r_misalign     <= 1'b0;
            r_bus_err      <= 1'b0;
        end else begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_misalign     <= 1'b0;
            r_bus_err      <= 1'b0;
            if (w_done) begin
                r_wb_valid     <= 1'b1;
                r_wb_reg_write <= r_reg_write;
                r_wb_rd        <= r_rd;
                r_wb_data      <= r_we ? r_addr : w_load_data;
                r_wb_pc        <= r_pc;
            end else if (w_timeout) begin
                r_wb_valid <= 1'b1;
                r_bus_err  <= 1'b1;
                r_wb_rd    <= r_rd;
                r_wb_pc    <= r_pc;
            end else if (!w_is_req && ex_valid && !w_mem_op) begin
                r_wb_valid     <= 1'b1;
                r_wb_reg_write <= ex_reg_write;
                r_wb_rd        <= ex_rd;
                r_wb_data      <= alu_out_in;
                r_wb_pc        <= current_pc_in;
            end else if (w_bad) begin
                r_wb_valid <= 1'b1;
                r_misalign <= 1'b1;
                r_wb_rd    <= ex_rd;
                r_wb_data  <= alu_out_in;
                r_wb_pc    <= current_pc_in;
            end
        end
    end

    assign wb_valid     = r_wb_valid;
    assign wb_reg_write = r_wb_reg_write;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign wb_pc        = r_wb_pc;
    assign misalign_out = r_misalign;
    assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios plus random ops against a word-array memory model.
module tb_mem_stage_lsu;

    localparam int TMO = 4;

    logic        clk, rst;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic [31:0] alu_out_in, rs2_data_in, current_pc_in;
    logic        stall_out, dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        wb_valid, wb_reg_write, misalign_out, bus_err, dbg_state;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, wb_pc;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem[0:63];

    mem_stage_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .alu_out_in(alu_out_in), .rs2_data_in(rs2_data_in), .current_pc_in(current_pc_in),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_pc(wb_pc), .misalign_out(misalign_out),
        .bus_err(bus_err), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int op_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit op_ok(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = op_size(f3);
        if (st && f3 > 3'd2) sz = 0;
        return (sz != 0) && ((a % sz) == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3, input int off);
        longint v, lim;
        int sz;
        sz  = op_size(f3);
        lim = longint'(1) << (8 * sz);
        v   = longint'(word >> (8 * off)) % lim;
        if (f3 < 3'd4 && sz < 4 && v >= lim / 2) v = v - lim;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        longint v;
        case (op_size(f3))
            1:       v = longint'(d % 256) * 64'h0101_0101;
            2:       v = longint'(d % 65536) * 64'h0001_0001;
            default: v = longint'(d);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic [2:0] f3, input int off);
        int m;
        m = ((1 << op_size(f3)) - 1) << off;
        return m[3:0];
    endfunction

    task automatic drive_idle();
        ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_funct3 = 0;
        ex_reg_write = 0; ex_rd = 0; alu_out_in = 0; rs2_data_in = 0; current_pc_in = 0;
    endtask

    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input bit rw,
                          input logic [4:0] rd, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] pc, input int lat);
        bit mem_op, ok;
        logic [31:0] word, wd;
        logic [3:0]  sb;
        mem_op = ld | st;
        ok     = mem_op && op_ok(st, f3, a);
        @(negedge clk);
        ex_valid = 1; ex_mem_read = ld; ex_mem_write = st; ex_funct3 = f3;
        ex_reg_write = rw; ex_rd = rd; alu_out_in = a; rs2_data_in = d; current_pc_in = pc;
        dmem_ready = 0;
        #1;
        check_eq("stall_issue", stall_out, ok);
        check_eq("req_in_idle", dmem_req, 0);
        if (!ok) begin
            @(negedge clk);
            ex_valid = 0;
            check_eq("wb_valid", wb_valid, 1);
            check_eq("wb_reg_write", wb_reg_write, mem_op ? 1'b0 : rw);
            check_eq("wb_rd", wb_rd, rd);
            check_eq("wb_pc", wb_pc, pc);
            check_eq("misalign", misalign_out, mem_op);
            check_eq("no_req", dmem_req, 0);
            if (!mem_op) begin
                exp_q.push_back(a);
                check_eq("wb_data_alu", wb_data, exp_q.pop_front());
            end
        end else begin
            @(negedge clk);
            wd = ref_wdata(f3, d);
            sb = ref_wstrb(f3, a % 4);
            check_eq("dmem_req", dmem_req, 1);
            check_eq("dmem_we", dmem_we, st);
            check_eq("dmem_addr", dmem_addr, a & 32'hFFFF_FFFC);
            check_eq("dmem_wstrb", dmem_wstrb, st ? sb : 4'd0);
            if (st) check_eq("dmem_wdata", dmem_wdata, wd);
            for (int k = 0; k < lat; k++) begin
                check_eq("stall_wait", stall_out, 1);
                @(negedge clk);
            end
            word = mem[a[7:2]];
            dmem_ready = 1;
            dmem_rdata = ld ? word : $urandom;
            #1;
            check_eq("stall_done", stall_out, 0);
            @(negedge clk);
            dmem_ready = 0;
            ex_valid = 0;
            check_eq("wb_valid", wb_valid, 1);
            check_eq("wb_reg_write", wb_reg_write, ld & rw);
            check_eq("wb_rd", wb_rd, rd);
            check_eq("wb_pc", wb_pc, pc);
            check_eq("misalign", misalign_out, 0);
            check_eq("bus_err", bus_err, 0);
            if (ld) begin
                exp_q.push_back(ref_load(word, f3, a % 4));
                check_eq("wb_data_load", wb_data, exp_q.pop_front());
            end else begin
                for (int i = 0; i < 4; i++) if (sb[i]) word[8*i +: 8] = wd[8*i +: 8];
                mem[a[7:2]] = word;
            end
        end
    endtask

    task automatic check_bubble();
        @(negedge clk);
        check_eq("bubble_valid", wb_valid, 0);
        check_eq("bubble_misalign", misalign_out, 0);
        check_eq("bubble_state", dbg_state, 0);
    endtask

    initial begin
        logic [2:0]  ld_f3 [5];
        logic [2:0]  bad_f3 [3];
        int          kind, sz;
        logic [31:0] a;
        bit          is_ld;
        ld_f3  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bad_f3 = '{3'd3, 3'd6, 3'd7};
        for (int i = 0; i < 64; i++) mem[i] = $urandom;

        // clock/reset
        drive_idle();
        rst = 0; dmem_ready = 0; dmem_rdata = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_req", dmem_req, 0);
        check_eq("rst_stall", stall_out, 0);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_wb_data", wb_data, 0);
        check_eq("rst_wb_pc", wb_pc, 0);
        check_eq("rst_misalign", misalign_out, 0);
        check_eq("rst_bus_err", bus_err, 0);
        check_eq("rst_state", dbg_state, 0);
        rst = 1;

        // directed scenarios
        run_op(0, 0, 3'd0, 1, 5'd5, 32'h0000_1234, 0, 32'h0000_0040, 0);
        check_bubble();
        mem[0] = 32'h80FF_FF7F;
        run_op(1, 0, 3'd0, 1, 5'd7, 32'h0000_0103, 0, 32'h0000_0044, 3);
        check_bubble();
        run_op(0, 1, 3'd1, 0, 5'd0, 32'h0000_0202, 32'hABCD_1234, 32'h0000_0048, 1);
        check_bubble();
        run_op(1, 0, 3'd2, 1, 5'd9, 32'h0000_0101, 0, 32'h0000_004C, 0);
        check_bubble();

        // timeout: ready never arrives
        @(negedge clk);
        ex_valid = 1; ex_mem_read = 1; ex_funct3 = 3'd2; ex_reg_write = 1; ex_rd = 5'd3;
        alu_out_in = 32'h0000_0010; current_pc_in = 32'h0000_0050;
        #1 check_eq("tmo_stall_issue", stall_out, 1);
        @(negedge clk);
        for (int k = 0; k < TMO - 1; k++) begin
            check_eq("tmo_wait_stall", stall_out, 1);
            check_eq("tmo_wait_err", bus_err, 0);
            check_eq("tmo_wait_state", dbg_state, 1);
            @(negedge clk);
        end
        check_eq("tmo_last_stall", stall_out, 0);
        check_eq("tmo_last_req", dmem_req, 1);
        @(negedge clk);
        ex_valid = 0;
        check_eq("tmo_bus_err", bus_err, 1);
        check_eq("tmo_wb_valid", wb_valid, 1);
        check_eq("tmo_wb_reg_write", wb_reg_write, 0);
        check_eq("tmo_state", dbg_state, 0);
        @(negedge clk);
        check_eq("tmo_err_pulse", bus_err, 0);
        check_eq("tmo_req_gone", dmem_req, 0);

        // reset mid-access
        @(negedge clk);
        ex_valid = 1; ex_mem_read = 1; ex_funct3 = 3'd2; ex_reg_write = 1; ex_rd = 5'd4;
        alu_out_in = 32'h0000_0020; current_pc_in = 32'h0000_0054;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_req", dmem_req, 1);
        drive_idle();
        rst = 0;
        @(negedge clk);
        check_eq("mid_rst_req", dmem_req, 0);
        check_eq("mid_rst_stall", stall_out, 0);
        check_eq("mid_rst_wb_valid", wb_valid, 0);
        check_eq("mid_rst_state", dbg_state, 0);
        rst = 1;
        run_op(0, 0, 3'd0, 1, 5'd6, 32'h0000_5555, 0, 32'h0000_0058, 0);
        run_op(1, 0, 3'd2, 1, 5'd8, 32'h0000_0024, 0, 32'h0000_005C, 2);
        check_bubble();

        // random traffic
        for (int n = 0; n < 160; n++) begin
            kind = $urandom_range(0, 9);
            a = 32'h1000_0000 + $urandom_range(0, 255);
            if (kind <= 2) begin
                run_op(0, 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       $urandom, 0, $urandom, 0);
            end else if (kind <= 8) begin
                is_ld = (kind <= 5);
                ex_funct3 = is_ld ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
                sz = op_size(ex_funct3);
                if ($urandom_range(0, 3) != 0) a = a - (a % sz);
                run_op(is_ld, !is_ld, ex_funct3, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       a, $urandom, $urandom, $urandom_range(0, TMO - 1));
            end else begin
                is_ld = 1'($urandom_range(0, 1));
                run_op(is_ld, !is_ld, bad_f3[$urandom_range(0, 2)], 1, 5'($urandom_range(0, 31)),
                       a, $urandom, $urandom, 0);
            end
            if ($urandom_range(0, 1) == 1) check_bubble();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
